// File: rtl/country_sensor_req.sv
// ---------------------------------------------------------------------------
// country_sensor_req
// Country-road vehicle detector front end for a highway/country signal
// controller. Synchronizes and debounces the loop detector, counts queued
// vehicles, discharges them while the country approach is green, and raises
// a registered request (x) whenever vehicles are waiting or being served.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : synchronous reset, active high
//   sensor_raw : asynchronous loop detector, high while a vehicle is present
//   coun_green : high while the country approach shows green
//   x          : registered vehicle-waiting request (WAIT or SERVE)
//   car_count  : number of queued country vehicles (saturates at MAX_CARS)
//   overflow   : sticky flag, an arrival was dropped at saturation
// ---------------------------------------------------------------------------
module country_sensor_req #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SERVE_CYCLES    = 3,
    parameter int MAX_CARS        = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_raw,
    input  logic       coun_green,
    output logic       x,
    output logic [3:0] car_count,
    output logic       overflow
);

    localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] SERVE_LAST = 4'(SERVE_CYCLES - 1);
    localparam logic [3:0] MAX_VAL    = 4'(MAX_CARS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    logic       r_sync1;
    logic       r_s;
    logic       r_deb;
    logic [3:0] r_stab_cnt;
    logic [3:0] r_dep_tmr;
    logic [3:0] r_count;
    logic       r_ovf;
    logic       r_x;
    state_t     r_state;

    logic       w_change;
    logic       w_accept;
    logic       w_arrival;
    logic       w_serving;
    logic       w_depart;
    logic [3:0] w_count_nxt;
    logic       w_ovf_set;
    state_t     w_state_nxt;

    // The accepted level change is applied on the same edge that the counter
    // would otherwise hit DEBOUNCE_CYCLES, so an arrival coincides with the
    // deb 0->1 edge and car_count/x update on that very edge.
    assign w_change  = (r_s != r_deb);
    assign w_accept  = w_change && (r_stab_cnt == DEB_LAST);
    assign w_arrival = w_accept && r_s;
    assign w_serving = coun_green && (r_count != 4'd0);
    assign w_depart  = w_serving && (r_dep_tmr == SERVE_LAST);

    // Queue count update and saturation detection
    always_comb begin
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        case ({w_arrival, w_depart})
            2'b10: begin
                if (r_count == MAX_VAL) begin
                    w_count_nxt = r_count;
                    w_ovf_set   = 1'b1;
                end else begin
                    w_count_nxt = r_count + 4'd1;
                end
            end
            2'b01:   w_count_nxt = r_count - 4'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arrival) w_state_nxt = ST_WAIT;
                else           w_state_nxt = ST_IDLE;
            end
            ST_WAIT: begin
                if (coun_green) w_state_nxt = ST_SERVE;
                else            w_state_nxt = ST_WAIT;
            end
            ST_SERVE: begin
                if (w_count_nxt == 4'd0) w_state_nxt = ST_IDLE;
                else if (!coun_green)    w_state_nxt = ST_WAIT;
                else                     w_state_nxt = ST_SERVE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Two-flop synchronizer for the asynchronous loop detector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_s     <= 1'b0;
        end else begin
            r_sync1 <= sensor_raw;
            r_s     <= r_sync1;
        end
    end

    // Debouncer: level accepted after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb      <= 1'b0;
            r_stab_cnt <= 4'd0;
        end else if (!w_change) begin
            r_stab_cnt <= 4'd0;
        end else if (w_accept) begin
            r_deb      <= r_s;
            r_stab_cnt <= 4'd0;
        end else begin
            r_stab_cnt <= r_stab_cnt + 4'd1;
        end
    end

    // Departure timer: a partial service period is discarded when green drops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dep_tmr <= 4'd0;
        end else if (!w_serving || w_depart) begin
            r_dep_tmr <= 4'd0;
        end else begin
            r_dep_tmr <= r_dep_tmr + 4'd1;
        end
    end

    // Queue count, sticky overflow, FSM state and registered request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
            r_ovf   <= 1'b0;
            r_state <= ST_IDLE;
            r_x     <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            r_state <= w_state_nxt;
            r_x     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign x         = r_x;
    assign car_count = r_count;
    assign overflow  = r_ovf;

endmodule
